// File: rtl/serial_to_parallel_nand.sv
// Serial-to-parallel word assembler with registered NAND reduction.
// Collects INPUT_WIDTH bits LSB first over a valid/ready handshake, then holds
// the completed word and its ~& flag until the consumer accepts it.
module serial_to_parallel_nand #(
  parameter  int INPUT_WIDTH = 8,
  localparam int CNT_WIDTH   = $clog2(INPUT_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   serialValid,
  input  logic                   serialData,
  output logic                   serialReady,
  output logic [INPUT_WIDTH-1:0] outputData,
  output logic                   nandData,
  output logic                   outputValid,
  input  logic                   outputReady
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(INPUT_WIDTH - 1);

  state_t                 state_q;
  logic [CNT_WIDTH-1:0]   count_q;
  logic [INPUT_WIDTH-1:0] shift_q;
  logic [INPUT_WIDTH-1:0] word_d;
  logic [INPUT_WIDTH-1:0] data_q;
  logic                   nand_q;
  logic                   accept;

  // Ready depends only on state (and reset), never on serialValid.
  assign serialReady = (state_q == FILL) & ~rst;
  assign accept      = serialValid & serialReady;
  assign outputValid = (state_q == HOLD);
  assign outputData  = data_q;
  assign nandData    = nand_q;

  // Partial word with the currently offered bit merged in at position count.
  always_comb begin
    word_d          = shift_q;
    word_d[count_q] = serialData;
  end

  // Control FSM, bit counter, shift register and registered output word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      count_q <= '0;
      shift_q <= '0;
      data_q  <= '0;
      nand_q  <= 1'b1;
    end else if (flush) begin
      // Output word and flag deliberately retain their last values.
      state_q <= FILL;
      count_q <= '0;
      shift_q <= '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept) begin
            if (count_q == LAST_CNT) begin
              data_q  <= word_d;
              nand_q  <= ~&word_d;
              count_q <= '0;
              shift_q <= '0;
              state_q <= HOLD;
            end else begin
              shift_q <= word_d;
              count_q <= count_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (outputReady) begin
            state_q <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_nand.sv
// Directed self-checking bench for serial_to_parallel_nand (INPUT_WIDTH = 8).
module tb_serial_to_parallel_nand;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       serialValid;
  logic       serialData;
  logic       serialReady;
  logic [7:0] outputData;
  logic       nandData;
  logic       outputValid;
  logic       outputReady;

  int vectors     = 0;
  int miscompares = 0;

  serial_to_parallel_nand #(.INPUT_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .serialValid (serialValid),
    .serialData  (serialData),
    .serialReady (serialReady),
    .outputData  (outputData),
    .nandData    (nandData),
    .outputValid (outputValid),
    .outputReady (outputReady)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Streams the low n bits of w, LSB first, one accept per cycle.
  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      serialValid = 1'b1;
      serialData  = w[i];
      step();
    end
    serialValid = 1'b0;
    serialData  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; serialValid = 1'b0; serialData = 1'b0; outputReady = 1'b0;

    // Reset then idle
    step(); step();
    chk("rst_data",  outputData,  8'h00);
    chk("rst_nand",  nandData,    1'b1);
    chk("rst_valid", outputValid, 1'b0);
    chk("rst_ready_during_rst", serialReady, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_ready_after", serialReady, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_valid", outputValid, 1'b0);
      chk("idle_ready", serialReady, 1'b1);
      chk("idle_data",  outputData,  8'h00);
    end

    // Back-to-back word 0xA5 with outputReady held high
    outputReady = 1'b1;
    send_bits(8'hA5, 7);
    chk("a5_valid_after7", outputValid, 1'b0);
    send_bits(8'h01, 1);                       // bit7 of 0xA5 is 1
    chk("a5_valid", outputValid, 1'b1);
    chk("a5_data",  outputData,  8'hA5);
    chk("a5_nand",  nandData,    1'b1);
    chk("a5_ready", serialReady, 1'b0);
    serialValid = 1'b1; serialData = 1'b0;     // offered during handshake, must be ignored
    step();
    chk("a5_done_valid", outputValid, 1'b0);
    chk("a5_done_ready", serialReady, 1'b1);

    // All-ones word with backpressure
    outputReady = 1'b0;
    send_bits(8'hFF, 8);
    for (int i = 0; i < 5; i++) begin
      chk("ff_valid", outputValid, 1'b1);
      chk("ff_data",  outputData,  8'hFF);
      chk("ff_nand",  nandData,    1'b0);
      chk("ff_ready", serialReady, 1'b0);
      serialValid = i[0]; serialData = 1'b0;   // stray pulses while held
      step();
    end
    serialValid = 1'b0;
    outputReady = 1'b1;
    step();
    chk("ff_release_valid", outputValid, 1'b0);
    chk("ff_keep_data",     outputData,  8'hFF);
    send_bits(8'h01, 8);
    chk("w01_valid", outputValid, 1'b1);
    chk("w01_data",  outputData,  8'h01);
    chk("w01_nand",  nandData,    1'b1);
    step();

    // Gapped input 0x3C, serialValid toggling every cycle
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w = 8'h3C;
      serialValid = 1'b1; serialData = w[i];
      step();
      if (i < 7) begin
        serialValid = 1'b0;
        step();
        chk("gap_valid_early", outputValid, 1'b0);
      end
    end
    serialValid = 1'b0;
    chk("gap_valid", outputValid, 1'b1);
    chk("gap_data",  outputData,  8'h3C);
    chk("gap_nand",  nandData,    1'b1);
    step();

    // Flush mid-word
    send_bits(8'h07, 3);
    flush = 1'b1; serialValid = 1'b1; serialData = 1'b1;
    step();
    flush = 1'b0; serialValid = 1'b0;
    chk("flush_valid",     outputValid, 1'b0);
    chk("flush_keep_data", outputData,  8'h3C);
    chk("flush_ready",     serialReady, 1'b1);
    send_bits(8'h0F, 8);
    chk("flush_w_valid", outputValid, 1'b1);
    chk("flush_w_data",  outputData,  8'h0F);
    chk("flush_w_nand",  nandData,    1'b1);
    step();

    // Flush and outputReady together in HOLD: word dropped, outputs retained
    outputReady = 1'b0;
    send_bits(8'h80, 8);
    chk("fh_valid_pre", outputValid, 1'b1);
    flush = 1'b1; outputReady = 1'b1;
    step();
    flush = 1'b0;
    chk("fh_valid", outputValid, 1'b0);
    chk("fh_data",  outputData,  8'h80);
    chk("fh_ready", serialReady, 1'b1);

    // Reset mid-word
    send_bits(8'h1F, 5);
    rst = 1'b1;
    step();
    chk("rmid_data",  outputData,  8'h00);
    chk("rmid_nand",  nandData,    1'b1);
    chk("rmid_valid", outputValid, 1'b0);
    rst = 1'b0;
    #1;
    chk("rmid_ready", serialReady, 1'b1);
    outputReady = 1'b0;
    send_bits(8'h5A, 7);
    chk("rmid_count_7", outputValid, 1'b0);
    send_bits(8'h00, 1);                       // bit7 of 0x5A is 0
    chk("rmid_w_valid", outputValid, 1'b1);
    chk("rmid_w_data",  outputData,  8'h5A);
    chk("rmid_w_nand",  nandData,    1'b1);

    // Reset in HOLD
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rhold_data",  outputData,  8'h00);
    chk("rhold_nand",  nandData,    1'b1);
    chk("rhold_valid", outputValid, 1'b0);
    #1;
    chk("rhold_ready", serialReady, 1'b1);
    send_bits(8'hC3, 8);
    chk("rhold_w_data", outputData, 8'hC3);
    chk("rhold_w_nand", nandData,   1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
